nios_usb_irq_pio: RTL and testbench
===================================

NIOS_USB_IRQ_PIO -- requirements
Module: nios_usb_irq_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of interrupt/status input lines, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on in_port, 2..4.
REQ-003 clk  in  1  single clock for all state.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 address  in  2  Avalon-MM slave register select.
REQ-006 chipselect  in  1  slave select.
REQ-007 read_n  in  1  active-low read strobe.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data.
REQ-010 in_port  in  WIDTH  asynchronous status lines from the USB controller.
REQ-011 readdata  out  32  registered read data.
REQ-012 irq  out  1  level interrupt to the CPU, active-high.

Function
REQ-013 The register map SHALL be: 0 data (RO), 1 reserved (reads 0, writes ignored), 2 irqmask (RW), 3 edgecapture (read, write-1-to-clear).
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep flop chain; sync_out is the last stage; prev is a further flop of sync_out.
REQ-015 Rising edge on bit i SHALL be sync_out[i] & ~prev[i]; only rising edges are captured.
REQ-016 A write occurs when chipselect=1 and write_n=0; it commits on the clk edge of that cycle; zero wait states.
REQ-017 Write to address 2 SHALL load irqmask <= writedata[WIDTH-1:0]; writedata[31:WIDTH] ignored.
REQ-018 Write to address 3 SHALL clear edgecapture[i] for each i with writedata[i]=1; bits with 0 are unchanged.
REQ-019 edgecapture[i] SHALL be set on any cycle where a rising edge on bit i is detected and stays set until cleared.
REQ-020 Simultaneous edge detect and write-1-to-clear on the same bit in the same cycle: set wins (bit remains 1).
REQ-021 Writes to addresses 0 and 1 SHALL have no effect.
REQ-022 readdata SHALL be registered every clk edge from mux(address): 0 -> zero-extended sync_out, 1 -> 0, 2 -> zero-extended irqmask, 3 -> zero-extended edgecapture; read latency is 1 cycle.
REQ-023 read_n and chipselect SHALL have no side effects; reading edgecapture does not clear it.
REQ-024 irq SHALL be the combinational OR of (edgecapture & irqmask), derived only from registers (glitch-free).
REQ-025 Latency: in_port rising before clk edge k SHALL be visible in edgecapture and irq after edge k+SYNC_STAGES.
REQ-026 Input pulses shorter than one clk period may be missed; pulses held >= 2 clk periods SHALL be captured exactly once per rising edge.
REQ-027 Masking a pending bit SHALL deassert irq next cycle without clearing edgecapture; unmasking SHALL reassert irq.

Reset
REQ-028 While reset=1, synchronizer flops, prev, irqmask, edgecapture and readdata SHALL be 0 and irq SHALL be 0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL discard pending captures and in-flight synchronizer data immediately.
REQ-030 An in_port bit held high across reset deassertion SHALL be captured as one rising edge after SYNC_STAGES+1 clocks (prev resets to 0).

Verification
REQ-031 Reset, then read addresses 0..3 with in_port=0 -> readdata 0x00000000 each, irq=0.
REQ-032 Write irqmask=0x5; raise in_port[0] -> edgecapture=0x1 and irq=1 after edge k+2 (SYNC_STAGES=2); read address 3 -> 0x00000001.
REQ-033 Raise in_port[1] with irqmask=0x5 -> edgecapture=0x2, irq stays 0; write irqmask=0x7 -> irq=1 next cycle.
REQ-034 edgecapture=0x3, write 0x1 to address 3 -> edgecapture=0x2; write 0xFFFFFFFF -> 0x0, irq=0.
REQ-035 Rising edge on bit 2 in same cycle as write 0x4 to address 3 -> edgecapture[2]=1 afterwards.
REQ-036 Pending edgecapture=0xF, assert reset mid-cycle -> all registers, readdata and irq 0 immediately; in_port=0x0 after release -> no capture.

Source files
------------

// File: rtl/nios_usb_irq_pio.sv
// Avalon-MM interrupt/status PIO for the USB controller.
// Synchronizes the status lines, latches their rising edges into a sticky
// edgecapture register, and raises a level IRQ for any edge whose mask bit is set.
module nios_usb_irq_pio #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecapture;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_edgecapture_nxt;
    logic [31:0]      w_rd_mux;
    logic             w_unused_ok;

    // Reads have no side effects, and the upper write-data bits never matter.
    assign w_unused_ok = &{1'b0, read_n, writedata};

    assign w_wr       = chipselect & ~write_n;
    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_sync_out & ~r_prev;

    // Metastability chain on the asynchronous status lines, plus the prev flop for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_out;
        end
    end

    // Interrupt mask register, loaded from the low WIDTH bits of the write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr && address == ADDR_MASK) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Write-1-to-clear mask for edgecapture; zero when no clear write is in progress.
    always_comb begin
        w_clear = '0;
        if (w_wr && address == ADDR_EDGE) begin
            w_clear = writedata[WIDTH-1:0];
        end
    end

    // A new edge is OR-ed in after the clear so that a coincident edge survives.
    assign w_edgecapture_nxt = (r_edgecapture & ~w_clear) | w_edge;

    // Sticky edge capture register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecapture <= '0;
        end else begin
            r_edgecapture <= w_edgecapture_nxt;
        end
    end

    // Read-back mux; address 1 is reserved and reads as zero.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux = 32'(w_sync_out);
            ADDR_MASK: w_rd_mux = 32'(r_irqmask);
            ADDR_EDGE: w_rd_mux = 32'(r_edgecapture);
            default:   w_rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle, giving a fixed one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    // Built only from flops, so the interrupt line cannot glitch on input activity.
    assign irq      = |(r_edgecapture & r_irqmask);

endmodule

// File: tb/tb_nios_usb_irq_pio.sv
// Directed self-checking bench for nios_usb_irq_pio (WIDTH=4, SYNC_STAGES=2).
module tb_nios_usb_irq_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    nios_usb_irq_pio #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        tick();
        d          = readdata;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    logic [31:0] rd;

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = '0; in_port = '0;
        tick();
        tick();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        tick();

        // Idle readback of every register
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check($sformatf("idle_rd%0d", a), rd, 32'h0);
        end
        check("idle_irq", {31'b0, irq}, 32'h0);

        // Mask bits 0 and 2, then raise bit 0 and watch the two-stage latency
        bus_write(2'd2, 32'h5);
        bus_read(2'd2, rd);
        check("mask_rd", rd, 32'h5);
        in_port = 4'h1;
        tick();
        tick();
        check("lat_k1_irq", {31'b0, irq}, 32'h0);
        tick();
        check("lat_k2_irq", {31'b0, irq}, 32'h1);
        bus_read(2'd3, rd);
        check("ec_bit0", rd, 32'h1);
        bus_read(2'd3, rd);
        check("ec_read_no_clear", rd, 32'h1);

        // Clear bit 0, then an unmasked-off edge on bit 1
        bus_write(2'd3, 32'h1);
        check("clr0_irq", {31'b0, irq}, 32'h0);
        in_port = 4'h3;
        tick(); tick(); tick();
        bus_read(2'd3, rd);
        check("ec_bit1", rd, 32'h2);
        check("bit1_masked_irq", {31'b0, irq}, 32'h0);
        bus_write(2'd2, 32'h7);
        check("unmask_irq", {31'b0, irq}, 32'h1);
        bus_write(2'd2, 32'h5);
        check("remask_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd);
        check("remask_ec_kept", rd, 32'h2);
        bus_write(2'd2, 32'h7);
        check("reunmask_irq", {31'b0, irq}, 32'h1);

        // Build edgecapture=0x3 by re-pulsing bit 0, then partial and full clear
        in_port = 4'h2;
        tick(); tick(); tick();
        in_port = 4'h3;
        tick(); tick(); tick();
        bus_read(2'd3, rd);
        check("ec_3", rd, 32'h3);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd);
        check("ec_clr1", rd, 32'h2);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rd);
        check("ec_clrall", rd, 32'h0);
        check("clrall_irq", {31'b0, irq}, 32'h0);

        // Edge on bit 2 coincides with a clear of bit 2: the edge wins
        in_port = 4'h7;
        tick();
        tick();
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rd);
        check("set_wins", rd, 32'h4);
        bus_write(2'd3, 32'h4);
        tick(); tick();
        bus_read(2'd3, rd);
        check("held_no_recapture", rd, 32'h0);

        // Writes to data and reserved addresses do nothing
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd2, rd);
        check("ro_mask_kept", rd, 32'h7);
        bus_read(2'd3, rd);
        check("ro_ec_kept", rd, 32'h0);
        bus_read(2'd1, rd);
        check("reserved_rd", rd, 32'h0);
        bus_read(2'd0, rd);
        check("data_rd", rd, 32'h7);

        // All four bits pending, then an asynchronous reset mid-cycle
        in_port = 4'h0;
        tick(); tick(); tick();
        in_port = 4'hF;
        tick(); tick(); tick(); tick();
        bus_read(2'd3, rd);
        check("ec_F", rd, 32'hF);
        check("ec_F_irq", {31'b0, irq}, 32'h1);
        address = 2'd3;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        in_port = 4'h0;
        tick();
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        bus_read(2'd3, rd);
        check("post_rst_ec", rd, 32'h0);
        bus_read(2'd2, rd);
        check("post_rst_mask", rd, 32'h0);
        bus_read(2'd0, rd);
        check("post_rst_data", rd, 32'h0);

        // Line held high across reset release is seen as one edge after three clocks
        reset   = 1'b1;
        in_port = 4'h1;
        address = 2'd3;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("held_rst_e3", readdata, 32'h0);
        tick();
        check("held_rst_e4", readdata, 32'h1);
        bus_write(2'd3, 32'h1);
        tick(); tick();
        bus_read(2'd3, rd);
        check("held_rst_once", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
